serial_byte_tx: RTL and testbench

SERIAL_BYTE_TX -- requirements
Module: serial_byte_tx

---
 rtl/serial_byte_tx.sv | 178 +++++++++++++++++
 tb/tb_serial_byte_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_byte_tx : byte FIFO feeding an 8N1 serial transmitter
// Revision 1.0
// ---------------------------------------------------------------------------
module serial_byte_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] byte_in,
  input  logic       byte_load,
  input  logic       clear_ovf,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic [4:0] fifo_count,
  output logic       overflow
);

  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH     = 5'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [4:0]    count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic full;
  logic push;
  logic drop;
  logic pop;
  logic baud_end;

  // Fullness is judged on the registered count, so a load that meets a pop
  // while full is still dropped.
  assign full     = (count_q == DEPTH);
  assign push     = byte_load && !full;
  assign drop     = byte_load && full;
  assign baud_end = (baud_q == BAUD_LAST);
  assign pop      = (count_q != 5'd0) &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_end));

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = byte_in;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        baud_d = 16'd0;
        if (pop) begin
          state_d = ST_START;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (pop) begin
            state_d = ST_START;
            shift_d = mem_q[rd_ptr_q];
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line and busy flag follow the state one cycle later, which places the
  // start bit two edges after the load into an empty, idle transmitter.
  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE) || (count_q != 5'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= 5'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_tx.sv
`default_nettype none
// tb_serial_byte_tx : directed and random checks of serial_byte_tx against a
// frame-level reference model (expected-byte queue plus 8N1 waveform rule).
module tb_serial_byte_tx;

  localparam int CPB    = 4;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * CPB;
  localparam int PERIOD = 10;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] byte_in   = 8'h00;
  logic       byte_load = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  time        start_times[$];
  int         mon_k = -1;
  logic [7:0] mon_byte = 8'h00;

  logic [7:0] b;
  int         n;
  int         gap;
  int         base;
  time        t_load;

  always #(PERIOD / 2) clk = ~clk;

  serial_byte_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_in    (byte_in),
    .byte_load  (byte_load),
    .clear_ovf  (clear_ovf),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 8N1 line level for sample k (0..FRAME-1) of a frame carrying byte v.
  function automatic logic frame_bit(input logic [7:0] v, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return v[slot - 1];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    byte_in   = v;
    byte_load = 1'b1;
    tick();
    byte_load = 1'b0;
    byte_in   = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int cnt;
    cnt = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0 || mon_k >= 0) && cnt < budget) begin
      tick();
      cnt++;
    end
    chk({tag, "_idle_timeout"}, 32'(cnt < budget), 32'd1);
  endtask

  task automatic wait_start(input int want, input int budget, input string tag);
    int cnt;
    cnt = 0;
    while (start_times.size() < want && cnt < budget) begin
      tick();
      cnt++;
    end
    chk({tag, "_start_timeout"}, 32'(cnt < budget), 32'd1);
  endtask

  // Line monitor: every frame seen on tx must be the next accepted byte,
  // bit-exact at every clock of its 10*CPB cycles.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_k = -1;
    end else begin
      if (mon_k < 0 && tx === 1'b0) begin
        start_times.push_back($time);
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) mon_byte = exp_q.pop_front();
        else mon_byte = 8'h00;
        mon_k = 0;
      end
      if (mon_k >= 0) begin
        chk($sformatf("frame_%02h_sample%0d", mon_byte, mon_k),
            {31'b0, tx}, {31'b0, frame_bit(mon_byte, mon_k)});
        mon_k++;
        if (mon_k == FRAME) mon_k = -1;
      end
    end
  end

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_full", {31'b0, fifo_full}, 32'd0);
    chk("rst_count", {27'b0, fifo_count}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_tx", {31'b0, tx}, 32'd1);

    // single 0xA5 frame: latency and busy window
    exp_q.push_back(8'hA5);
    load(8'hA5);
    t_load = $time;
    chk("a5_count_after_load", {27'b0, fifo_count}, 32'd1);
    chk("a5_tx_load_plus0", {31'b0, tx}, 32'd1);
    tick();
    chk("a5_count_after_pop", {27'b0, fifo_count}, 32'd0);
    chk("a5_tx_load_plus1", {31'b0, tx}, 32'd1);
    chk("a5_busy_load_plus1", {31'b0, busy}, 32'd1);
    wait_start(1, 10, "a5");
    chk("a5_start_latency", 32'($time - t_load), 32'(2 * PERIOD));
    repeat (FRAME - 1) tick();
    chk("a5_busy_last_stop", {31'b0, busy}, 32'd1);
    tick();
    chk("a5_busy_drop", {31'b0, busy}, 32'd0);
    chk("a5_tx_idle", {31'b0, tx}, 32'd1);

    // back-to-back frames
    wait_idle(100, "b2b_pre");
    base = start_times.size();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    load(8'h01);
    load(8'h80);
    chk("b2b_count", {27'b0, fifo_count}, 32'd1);
    wait_start(base + 2, 3 * FRAME, "b2b");
    if (start_times.size() >= base + 2)
      chk("b2b_spacing", 32'(start_times[base + 1] - start_times[base]), 32'(FRAME * PERIOD));
    wait_idle(3 * FRAME, "b2b");

    // six loads while idle: fill and overflow, then clear
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (i < 5) exp_q.push_back(b);
      load(b);
    end
    chk("fill_count", {27'b0, fifo_count}, 32'd4);
    chk("fill_full", {31'b0, fifo_full}, 32'd1);
    chk("fill_ovf", {31'b0, overflow}, 32'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("fill_ovf_cleared", {31'b0, overflow}, 32'd0);
    wait_idle(7 * FRAME, "fill");

    // load while full coinciding with the STOP->START pop
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      load(b);
    end
    chk("pop_full_pre", {31'b0, fifo_full}, 32'd1);
    repeat (FRAME - 4) tick();
    chk("pop_count_pre", {27'b0, fifo_count}, 32'd4);
    load(8'($urandom));
    chk("pop_drop_count", {27'b0, fifo_count}, 32'd3);
    chk("pop_drop_ovf", {31'b0, overflow}, 32'd1);

    // clear alone, then clear racing a drop
    b = 8'($urandom);
    exp_q.push_back(b);
    load(b);
    chk("race_count_full", {27'b0, fifo_count}, 32'd4);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("race_clear_alone", {31'b0, overflow}, 32'd0);
    clear_ovf = 1'b1;
    byte_in   = 8'($urandom);
    byte_load = 1'b1;
    tick();
    byte_load = 1'b0;
    clear_ovf = 1'b0;
    chk("race_set_wins", {31'b0, overflow}, 32'd1);
    chk("race_count_kept", {27'b0, fifo_count}, 32'd4);
    wait_idle(7 * FRAME, "race");

    // reset in the middle of DATA
    base = start_times.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h3C);
    load(8'h00);
    load(8'h3C);
    wait_start(base + 1, 10, "rst_mid");
    repeat (10) tick();
    chk("rst_mid_tx_low", {31'b0, tx}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_tx", {31'b0, tx}, 32'd1);
    chk("rst_mid_count", {27'b0, fifo_count}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_ovf", {31'b0, overflow}, 32'd0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    base = start_times.size();
    repeat (3 * FRAME / 2) tick();
    chk("rst_mid_no_frame", 32'(start_times.size()), 32'(base));
    chk("rst_mid_tx_idle", {31'b0, tx}, 32'd1);
    chk("rst_mid_busy_idle", {31'b0, busy}, 32'd0);
    b = 8'($urandom);
    exp_q.push_back(b);
    load(b);
    wait_idle(2 * FRAME, "rst_resume");
    chk("rst_resume_one_frame", 32'(start_times.size()), 32'(base + 1));

    // random bursts with gaps; byte_in wiggles while byte_load is low
    repeat (8) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        load(b);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          byte_in = 8'($urandom);
          tick();
        end
      end
      wait_idle(6 * FRAME, "rand");
    end
    chk("rand_no_overflow", {31'b0, overflow}, 32'd0);
    chk("rand_count_empty", {27'b0, fifo_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
